// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: hazard FSM encoding
// and register-index width.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from ID/EX/MEM and the
// stall/flush/freeze controls returned to the pipeline registers.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import pipeline_pkg::*;

  logic [REG_W-1:0] id_RegisterRs;
  logic [REG_W-1:0] id_RegisterRt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_jump;
  logic             exe_MemRead;
  logic             exe_RegWrite;
  logic [REG_W-1:0] exe_RegisterRt;
  logic             exe_branch_taken;
  logic             mem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             stall;
  logic             freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side drives the hazard sources and consumes the controls.
  modport master (
    output id_RegisterRs, id_RegisterRt, id_use_rs, id_use_rt, id_jump,
           exe_MemRead, exe_RegWrite, exe_RegisterRt, exe_branch_taken,
           mem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, stall, freeze, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_RegisterRs, id_RegisterRt, id_use_rs, id_use_rt, id_jump,
           exe_MemRead, exe_RegWrite, exe_RegisterRt, exe_branch_taken,
           mem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, stall, freeze, mem_err,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / control / data-memory hazard controller for the 5-stage core.
// Controls are combinational from state and inputs; counters and mem_err are registered.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  hz_state_t      state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           err_set, err_q;
  logic           loaduse, rs_hit, rt_hit;
  logic           pc_w, ifid_w, flush, bubble, frz;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // A load to $zero never produces data, so it can never be a hazard.
  assign rs_hit  = hz.id_use_rs && (hz.id_RegisterRs == hz.exe_RegisterRt);
  assign rt_hit  = hz.id_use_rt && (hz.id_RegisterRt == hz.exe_RegisterRt);
  assign loaduse = hz.exe_MemRead && hz.exe_RegWrite &&
                   (hz.exe_RegisterRt != REG_ZERO) && (rs_hit || rt_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    frz       = 1'b0;
    case (state)
      RUN: begin
        if (hz.mem_req && !hz.dmem_ready) begin
          frz       = 1'b1;
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          state_nxt = MEMWAIT;
          wait_nxt  = WCW'(1);
        end else if (hz.exe_branch_taken) begin
          // Taken branch squashes ID even if it also has a load-use or jump.
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (loaduse) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end else if (hz.id_jump) begin
          flush  = 1'b1;
        end
      end
      MEMWAIT: begin
        // Everything is held, so branch/jump/load-use get re-seen on return.
        frz    = 1'b1;
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        if (hz.dmem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
          err_set   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt  = wait_cnt + WCW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!pc_w),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

  assign hz.pc_write   = pc_w;
  assign hz.ifid_write = ifid_w;
  assign hz.ifid_flush = flush;
  assign hz.stall      = bubble;
  assign hz.freeze     = frz;
  assign hz.mem_err    = err_q;
  assign hz.stall_cnt  = stall_cnt;
  assign hz.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions each cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if #(.CNT_W(CW)) hz();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, jump, mrd, rw;
    logic [4:0] ert;
    logic       br, mreq, rdy;
  } stim_t;

  typedef struct packed {
    logic          pc, ifw, fl, st, fz, err;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: "waiting" flag plus count of cycles spent waiting.
  bit m_wait, m_err;
  int m_waited, m_sc, m_fc;

  task automatic drive(input stim_t s, input bit r);
    exp_t e;
    bit   lu;
    rst                 = r;
    hz.id_RegisterRs    = s.rs;
    hz.id_RegisterRt    = s.rt;
    hz.id_use_rs        = s.use_rs;
    hz.id_use_rt        = s.use_rt;
    hz.id_jump          = s.jump;
    hz.exe_MemRead      = s.mrd;
    hz.exe_RegWrite     = s.rw;
    hz.exe_RegisterRt   = s.ert;
    hz.exe_branch_taken = s.br;
    hz.mem_req          = s.mreq;
    hz.dmem_ready       = s.rdy;
    if (!r) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_sc = 0; m_fc = 0;
    end
    lu = s.mrd && s.rw && (s.ert != 0) &&
         ((s.use_rs && s.rs == s.ert) || (s.use_rt && s.rt == s.ert));
    e = '0;
    e.pc = 1; e.ifw = 1;
    if (m_wait || (s.mreq && !s.rdy)) begin
      e.fz = 1; e.pc = 0; e.ifw = 0;
    end else if (s.br) begin
      e.fl = 1; e.st = 1;
    end else if (lu) begin
      e.pc = 0; e.ifw = 0; e.st = 1;
    end else if (s.jump) begin
      e.fl = 1;
    end
    e.err = m_err;
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    q.push_back(e);
    if (r) begin
      if (!e.pc) m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
      if (e.fl)  m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
      if (m_wait) begin
        if (s.rdy)              m_wait = 0;
        else if (m_waited == TO) begin m_err = 1; m_wait = 0; end
        else                    m_waited++;
      end else if (s.mreq && !s.rdy) begin
        m_wait = 1; m_waited = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.stall, hz.freeze,
           hz.mem_err, hz.stall_cnt, hz.flush_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl@%0t got pc=%b ifw=%b fl=%b st=%b fz=%b err=%b sc=%0d fc=%0d want pc=%b ifw=%b fl=%b st=%b fz=%b err=%b sc=%0d fc=%0d",
                 $time, a.pc, a.ifw, a.fl, a.st, a.fz, a.err, a.sc, a.fc,
                 e.pc, e.ifw, e.fl, e.st, e.fz, e.err, e.sc, e.fc);
      end
    end
  end

  initial begin
    stim_t idle, lu, s;
    idle = '0;
    lu = idle;
    lu.mrd = 1; lu.rw = 1; lu.ert = 5'd8; lu.rs = 5'd8; lu.use_rs = 1;

    @(posedge clk); #1;
    drive(idle, 0);
    repeat (2) drive(idle, 1);

    // load-use, then the same with $zero as destination
    drive(lu, 1);
    drive(idle, 1);
    s = lu; s.ert = 0; s.rs = 0; drive(s, 1);
    s = lu; s.rs = 0; s.use_rs = 0; s.rt = 5'd8; s.use_rt = 1; drive(s, 1);
    s = lu; s.use_rs = 0; drive(s, 1);

    // branch beats load-use and jump
    s = lu; s.br = 1; s.jump = 1; drive(s, 1);
    s = idle; s.jump = 1; drive(s, 1);

    // memory wait: 3 not-ready cycles then ready
    drive(idle, 0);
    s = idle; s.mreq = 1;
    repeat (3) drive(s, 1);
    s.rdy = 1; drive(s, 1);
    drive(idle, 1);

    // reset in the middle of MEMWAIT
    s = idle; s.mreq = 1;
    repeat (3) drive(s, 1);
    drive(idle, 0);
    drive(idle, 1);

    // timeout and stickiness
    s = idle; s.mreq = 1;
    repeat (20) drive(s, 1);
    s.rdy = 1; drive(s, 1);
    repeat (3) drive(idle, 1);

    // flush counter saturation
    drive(idle, 0);
    s = idle; s.jump = 1;
    repeat (20) drive(s, 1);
    drive(idle, 1);

    // randomized traffic
    drive(idle, 0);
    for (int i = 0; i < 600; i++) begin
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.ert    = 5'($urandom_range(0, 3));
      s.use_rs = 1'($urandom);
      s.use_rt = 1'($urandom);
      s.mrd    = 1'($urandom);
      s.rw     = ($urandom_range(0, 3) != 0);
      s.jump   = ($urandom_range(0, 7) == 0);
      s.br     = ($urandom_range(0, 7) == 0);
      s.mreq   = ($urandom_range(0, 5) == 0);
      s.rdy    = ($urandom_range(0, 9) == 0);
      drive(s, ($urandom_range(0, 149) != 0));
    end
    repeat (2) drive(idle, 1);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
